// File: rtl/alu32_result_stage.sv
// -----------------------------------------------------------------------------
// alu32_result_stage
//
// Registered output stage behind the ALU's final 8-to-1 result select. Each
// accepted result is tagged with NZCV flags and queued in a 2-entry FIFO with
// valid/ready handshakes on both sides. A sticky flag records any accepted
// ADD/SUB that overflowed.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   producer handshake (in_ready = count != 2)
//   in_result, in_op      selected result and opcode {s2,s1,s0}
//   in_c, in_v            adder carry-out / signed overflow
//   out_valid / out_ready consumer handshake
//   out_result, out_op    head entry payload (holds last value when empty)
//   out_n/z/c/v           head entry flags
//   count                 entries held (0..2)
//   sticky_v, clr_sticky  sticky overflow flag and its clear
// -----------------------------------------------------------------------------
module alu32_result_stage #(
  parameter int DEPTH = 2,  // fixed; pointers are 1 bit wide
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_result,
  input  logic [2:0]   in_op,
  input  logic         in_c,
  input  logic         in_v,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [2:0]   out_op,
  output logic         out_n,
  output logic         out_z,
  output logic         out_c,
  output logic         out_v,
  output logic [1:0]   count,
  output logic         sticky_v,
  input  logic         clr_sticky
);

  typedef struct packed {
    logic [W-1:0] result;
    logic [2:0]   op;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } entry_t;

  entry_t     mem [2];
  entry_t     head_q, head_d, new_entry;
  logic       wr_ptr, rd_ptr, rd_d;
  logic [1:0] count_q, count_d;
  logic       push, pop, is_arith;

  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Opcodes 110 (ADD) and 111 (SUB) are the only ones driven by the adder.
  assign is_arith  = in_op[2] & in_op[1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    new_entry.result = in_result;
    new_entry.op     = in_op;
    new_entry.n      = in_result[W-1];
    new_entry.z      = (in_result == '0);
    new_entry.c      = is_arith & in_c;
    new_entry.v      = is_arith & in_v;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // The output register tracks whatever will be at the head after this edge.
  // When the incoming entry lands in the slot that becomes the head (push into
  // an empty FIFO, or push+pop with one entry) it bypasses the memory.
  always_comb begin
    head_d = head_q;
    rd_d   = rd_ptr ^ pop;
    if (count_d != 2'd0) begin
      if (push && (rd_d == wr_ptr)) head_d = new_entry;
      else                          head_d = mem[rd_d];
    end
  end

  // NOTE: the entry storage carries no reset; count and pointers alone
  // decide what is valid, so stale slot contents are never observed.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= new_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      head_q   <= '0;
      sticky_v <= 1'b0;
    end else begin
      count_q <= count_d;
      wr_ptr  <= wr_ptr ^ push;
      rd_ptr  <= rd_d;
      head_q  <= head_d;
      // A coinciding set takes priority over the clear.
      if (push && is_arith && in_v) sticky_v <= 1'b1;
      else if (clr_sticky)          sticky_v <= 1'b0;
    end
  end

  assign count      = count_q;
  assign out_result = head_q.result;
  assign out_op     = head_q.op;
  assign out_n      = head_q.n;
  assign out_z      = head_q.z;
  assign out_c      = head_q.c;
  assign out_v      = head_q.v;

endmodule
